// File: rtl/bayer_raw2rgb_if.sv
// -----------------------------------------------------------------------------
// bayer_raw2rgb_if
// Pixel bus between the capture block, the Bayer-to-RGB converter and the
// gain/offset stage downstream.
//   iDATA    raw Bayer pixel
//   iDVAL    iDATA / iX_Cont / iY_Cont valid this cycle
//   iX_Cont  column index of iDATA (0 at line start)
//   iY_Cont  row index of iDATA (0 at frame start)
//   oRed/oGreen/oBlue  RGB components of the reconstructed pixel
//   oDVAL    RGB valid
// Modports:
//   master : pixel source (drives raw side, observes RGB side)
//   slave  : converter (consumes raw side, drives RGB side)
// -----------------------------------------------------------------------------
interface bayer_raw2rgb_if #(
  parameter int DATA_WIDTH = 10,
  parameter int X_WIDTH    = 11,
  parameter int Y_WIDTH    = 11
);
  logic [DATA_WIDTH-1:0] iDATA;
  logic                  iDVAL;
  logic [X_WIDTH-1:0]    iX_Cont;
  logic [Y_WIDTH-1:0]    iY_Cont;
  logic [DATA_WIDTH-1:0] oRed;
  logic [DATA_WIDTH-1:0] oGreen;
  logic [DATA_WIDTH-1:0] oBlue;
  logic                  oDVAL;

  modport master (
    output iDATA, iDVAL, iX_Cont, iY_Cont,
    input  oRed, oGreen, oBlue, oDVAL
  );

  modport slave (
    input  iDATA, iDVAL, iX_Cont, iY_Cont,
    output oRed, oGreen, oBlue, oDVAL
  );
endinterface

// File: rtl/bayer_raw2rgb.sv
// -----------------------------------------------------------------------------
// bayer_raw2rgb
// Reconstructs one RGB pixel per valid raw Bayer pixel using a single line
// buffer and a 2x2 window (current pixel, left neighbour, pixel above and
// above-left). Fixed two-cycle latency from iDVAL to oDVAL.
// Ports:
//   iCLK    pixel clock, rising edge
//   iRST_N  asynchronous active-low reset
//   bus     bayer_raw2rgb_if.slave: raw pixel + counters in, RGB + oDVAL out
// Parameters:
//   DATA_WIDTH    raw / RGB component width
//   LINE_WIDTH    maximum active pixels per line (line buffer depth)
//   X_WIDTH       column counter width
//   Y_WIDTH       row counter width
//   BAYER_PATTERN 0=GRBG, 1=RGGB, 2=BGGR, 3=GBRG
// -----------------------------------------------------------------------------
module bayer_raw2rgb #(
  parameter int DATA_WIDTH    = 10,
  parameter int LINE_WIDTH    = 752,
  parameter int X_WIDTH       = 11,
  parameter int Y_WIDTH       = 11,
  parameter int BAYER_PATTERN = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  bayer_raw2rgb_if.slave    bus
);

  localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [X_WIDTH-1:0] LINE_LIMIT = X_WIDTH'(LINE_WIDTH);

  // Column/row parity of the red site within the 2x2 Bayer cell.
  localparam logic RED_X = (BAYER_PATTERN == 0) || (BAYER_PATTERN == 2);
  localparam logic RED_Y = (BAYER_PATTERN == 2) || (BAYER_PATTERN == 3);

  // ---------------------------------------------------------------------------
  // Line buffer: read-before-write at the current column. The registered read
  // is the pixel directly above the current one (tap P01). Not reset.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] lineBuf [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] aboveData;
  logic                  inLine;
  logic [AW-1:0]         bufAddr;

  assign inLine  = (bus.iX_Cont < LINE_LIMIT);
  assign bufAddr = bus.iX_Cont[AW-1:0];

  always_ff @(posedge iCLK) begin
    if (bus.iDVAL && inLine) begin
      aboveData        <= lineBuf[bufAddr];
      lineBuf[bufAddr] <= bus.iDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture current pixel, colour phase and boundary flag.
  // The phase is the current pixel's parity relative to the red site, so
  // phase 00 means the current pixel itself is red.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] s1Data;
  logic                  s1PhaseX;
  logic                  s1PhaseY;
  logic                  s1Zero;
  logic                  s1Dval;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1Data   <= '0;
      s1PhaseX <= 1'b0;
      s1PhaseY <= 1'b0;
      s1Zero   <= 1'b0;
      s1Dval   <= 1'b0;
    end else begin
      s1Dval <= bus.iDVAL;
      if (bus.iDVAL) begin
        s1Data   <= bus.iDATA;
        s1PhaseX <= bus.iX_Cont[0] ^ RED_X;
        s1PhaseY <= bus.iY_Cont[0] ^ RED_Y;
        // Incomplete window on first row/column; beyond the buffer nothing
        // valid exists above.
        s1Zero   <= (bus.iX_Cont == '0) || (bus.iY_Cont == '0) || !inLine;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: tap selection. Taps: P11 = s1Data, P10 = p10Reg (left),
  // P01 = aboveData (above), P00 = p00Reg (above-left).
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] p10Reg;
  logic [DATA_WIDTH-1:0] p00Reg;
  logic [DATA_WIDTH-1:0] redSel;
  logic [DATA_WIDTH-1:0] blueSel;
  logic [DATA_WIDTH-1:0] green1;
  logic [DATA_WIDTH-1:0] green2;
  logic [DATA_WIDTH:0]   greenSum;

  always_comb begin
    redSel  = s1Data;
    blueSel = p00Reg;
    green1  = p10Reg;
    green2  = aboveData;
    case ({s1PhaseY, s1PhaseX})
      2'b00: begin          // current pixel sits on the red site
        redSel  = s1Data;
        blueSel = p00Reg;
        green1  = p10Reg;
        green2  = aboveData;
      end
      2'b01: begin          // left neighbour is red, above is blue
        redSel  = p10Reg;
        blueSel = aboveData;
        green1  = s1Data;
        green2  = p00Reg;
      end
      2'b10: begin          // above is red, left neighbour is blue
        redSel  = aboveData;
        blueSel = p10Reg;
        green1  = s1Data;
        green2  = p00Reg;
      end
      default: begin        // current pixel sits on the blue site
        redSel  = p00Reg;
        blueSel = s1Data;
        green1  = p10Reg;
        green2  = aboveData;
      end
    endcase
    greenSum = {1'b0, green1} + {1'b0, green2};
  end

  logic [DATA_WIDTH-1:0] redReg;
  logic [DATA_WIDTH-1:0] greenReg;
  logic [DATA_WIDTH-1:0] blueReg;
  logic                  dvalReg;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      p10Reg   <= '0;
      p00Reg   <= '0;
      redReg   <= '0;
      greenReg <= '0;
      blueReg  <= '0;
      dvalReg  <= 1'b0;
    end else begin
      dvalReg <= s1Dval;
      if (s1Dval) begin
        // Window history advances only on valid pixels, so idle gaps are
        // transparent to the reconstruction.
        p10Reg <= s1Data;
        p00Reg <= aboveData;
        if (s1Zero) begin
          redReg   <= '0;
          greenReg <= '0;
          blueReg  <= '0;
        end else begin
          redReg   <= redSel;
          greenReg <= greenSum[DATA_WIDTH:1];
          blueReg  <= blueSel;
        end
      end
    end
  end

  assign bus.oRed   = redReg;
  assign bus.oGreen = greenReg;
  assign bus.oBlue  = blueReg;
  assign bus.oDVAL  = dvalReg;

endmodule

// File: tb/tb_bayer_raw2rgb.sv
// -----------------------------------------------------------------------------
// tb_bayer_raw2rgb
// Two converters (RGGB and BGGR, 8-pixel line buffer) share one raw stream.
// Expected RGB values are computed from the frame image held in the bench and
// queued per pixel; a negedge monitor pops and compares them along with the
// cycle the output was due.
// -----------------------------------------------------------------------------
module tb_bayer_raw2rgb;
  localparam int DW = 10;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int LW = 8;

  typedef struct {
    int  x;
    int  y;
    int  due;
    bit  flat;
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
  } expT;

  logic          clk   = 1'b0;
  logic          rstN  = 1'b1;
  logic [DW-1:0] dData = '0;
  logic          dDval = 1'b0;
  logic [XW-1:0] dX    = '0;
  logic [YW-1:0] dY    = '0;

  int  cyc      = 0;
  int  passCnt  = 0;
  int  totalCnt = 0;
  int  flatCnt  = 0;
  int  img [0:3][0:9];
  expT qA[$];
  expT qB[$];

  bayer_raw2rgb_if #(.DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW)) busA ();
  bayer_raw2rgb_if #(.DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW)) busB ();

  assign busA.iDATA   = dData;
  assign busA.iDVAL   = dDval;
  assign busA.iX_Cont = dX;
  assign busA.iY_Cont = dY;
  assign busB.iDATA   = dData;
  assign busB.iDVAL   = dDval;
  assign busB.iX_Cont = dX;
  assign busB.iY_Cont = dY;

  bayer_raw2rgb #(
    .DATA_WIDTH(DW), .LINE_WIDTH(LW), .X_WIDTH(XW), .Y_WIDTH(YW), .BAYER_PATTERN(1)
  ) dutA (
    .iCLK(clk), .iRST_N(rstN), .bus(busA)
  );

  bayer_raw2rgb #(
    .DATA_WIDTH(DW), .LINE_WIDTH(LW), .X_WIDTH(XW), .Y_WIDTH(YW), .BAYER_PATTERN(2)
  ) dutB (
    .iCLK(clk), .iRST_N(rstN), .bus(busB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: classify each of the four window pixels by its absolute parity
  // against the red site of the pattern.
  function automatic expT model(input int x, input int y, input int pat, input bit flat);
    expT e;
    int  rx;
    int  ry;
    int  gs;
    int  v;
    e.x = x; e.y = y; e.due = cyc + 2; e.flat = flat;
    e.r = '0; e.g = '0; e.b = '0;
    rx = (pat == 0 || pat == 2) ? 1 : 0;
    ry = (pat == 2 || pat == 3) ? 1 : 0;
    gs = 0;
    if (!(x == 0 || y == 0 || x >= LW)) begin
      for (int yy = y - 1; yy <= y; yy++) begin
        for (int xx = x - 1; xx <= x; xx++) begin
          v = img[yy][xx];
          if ((xx % 2) == rx && (yy % 2) == ry)      e.r = DW'(v);
          else if ((xx % 2) != rx && (yy % 2) != ry) e.b = DW'(v);
          else                                      gs += v;
        end
      end
      e.g = DW'(gs / 2);
    end
    return e;
  endfunction

  task automatic checkOut(input int id, input logic [DW-1:0] r, input logic [DW-1:0] g,
                          input logic [DW-1:0] b);
    expT   e;
    int    pending;
    string nm;
    nm      = (id == 0) ? "A" : "B";
    pending = (id == 0) ? qA.size() : qB.size();
    chk({nm, "_output_expected"}, (pending > 0) ? 1 : 0, 1);
    if (pending > 0) begin
      if (id == 0) e = qA.pop_front();
      else         e = qB.pop_front();
      if (id == 0 && e.flat) flatCnt++;
      chk($sformatf("%s_x%0d_y%0d_latency", nm, e.x, e.y), cyc, e.due);
      chk($sformatf("%s_x%0d_y%0d_red", nm, e.x, e.y), int'(r), int'(e.r));
      chk($sformatf("%s_x%0d_y%0d_green", nm, e.x, e.y), int'(g), int'(e.g));
      chk($sformatf("%s_x%0d_y%0d_blue", nm, e.x, e.y), int'(b), int'(e.b));
      $display("out %s x=%0d y=%0d R=%0d G=%0d B=%0d", nm, e.x, e.y, r, g, b);
    end
  endtask

  always @(negedge clk) begin
    if (busA.oDVAL) checkOut(0, busA.oRed, busA.oGreen, busA.oBlue);
    if (busB.oDVAL) checkOut(1, busB.oRed, busB.oGreen, busB.oBlue);
  end

  task automatic drivePix(input int x, input int y, input int v, input bit flat);
    @(posedge clk); #1;
    dDval = 1'b1;
    dX    = XW'(x);
    dY    = YW'(y);
    dData = DW'(v);
    img[y][x] = v;
    qA.push_back(model(x, y, 1, flat));
    qB.push_back(model(x, y, 2, 1'b0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      dDval = 1'b0;
    end
  endtask

  function automatic int pixVal(input int mode, input int x, input int y);
    if (mode == 0) return 100;
    if (mode == 1) begin
      if ((x % 2) == 0 && (y % 2) == 0) return 400;
      if ((x % 2) == 1 && (y % 2) == 1) return 50;
      if ((y % 2) == 0)                 return 200;
      return 203;
    end
    return int'($urandom_range(1023, 0));
  endfunction

  // mode: 0 flat 100, 1 RGGB test pattern, 2 random
  task automatic sendFrame(input int w, input int h, input int mode, input int maxGap);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (maxGap > 0) idle(int'($urandom_range(maxGap, 0)));
        drivePix(x, y, pixVal(mode, x, y), mode == 0);
      end
    end
  endtask

  task automatic rstCheck(input string tag);
    @(negedge clk);
    chk({tag, "_A_dval"},  int'(busA.oDVAL),  0);
    chk({tag, "_A_red"},   int'(busA.oRed),   0);
    chk({tag, "_A_green"}, int'(busA.oGreen), 0);
    chk({tag, "_A_blue"},  int'(busA.oBlue),  0);
    chk({tag, "_B_dval"},  int'(busB.oDVAL),  0);
    chk({tag, "_B_red"},   int'(busB.oRed),   0);
  endtask

  task automatic resetPulse(input string tag);
    @(posedge clk); #2;
    rstN = 1'b0;
    qA.delete();
    qB.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dDval = (i % 2 == 0);
      dX    = XW'(i);
      dY    = YW'(1);
      dData = DW'(i * 37 + 5);
      rstCheck(tag);
    end
    @(posedge clk); #2;
    dDval = 1'b0;
    rstN  = 1'b1;
  endtask

  initial begin
    // Reset with iDVAL toggling, then release.
    #2;
    resetPulse("reset");

    // Flat field: 32 outputs, forced zeros on row 0 / column 0.
    sendFrame(8, 4, 0, 0);
    idle(4);
    chk("flat_pulse_count", flatCnt, 32);

    // Pattern decode back-to-back, then the same frame with random gaps.
    sendFrame(8, 4, 1, 0);
    sendFrame(8, 4, 1, 3);

    // Overlong lines: columns 8,9 forced to zero, buffer left intact.
    sendFrame(10, 4, 2, 0);
    idle(3);

    // Mid-frame reset during row 2, then a complete fresh frame.
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (!(y == 2 && x > 3)) drivePix(x, y, pixVal(2, x, y), 1'b0);
      end
    end
    resetPulse("midreset");
    sendFrame(8, 4, 2, 0);
    idle(4);

    chk("A_queue_drained", qA.size(), 0);
    chk("B_queue_drained", qB.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
